// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage with memory-stall handshake
// Owns the PC; a hold buffer and pending-redirect register cover pipeline and memory stalls.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        proc_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_stall,
  output logic [31:0] PC_4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        IF_flush,
  output logic        if_stall
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        advance;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;

  assign advance      = pc_write & ~proc_stall;
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      buf_inst_q <= 32'd0;
      pend_pc_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_inst_d = buf_inst_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      RUN: begin
        if (imem_stall) begin
          if (redirect) begin
            pend_pc_d = redirect_tgt;
            state_d   = DRAIN;
          end
        end else if (advance) begin
          pc_d = redirect ? redirect_tgt : pc_plus4;
        end else begin
          buf_inst_d = imem_rdata;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d    = redirect ? redirect_tgt : pc_plus4;
          state_d = RUN;
        end
      end
      DRAIN: begin
        // A redirect arriving on the completion cycle is newer than pend_pc_q.
        if (redirect) pend_pc_d = redirect_tgt;
        if (!imem_stall) begin
          pc_d    = redirect ? redirect_tgt : pend_pc_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    imem_read  = 1'b0;
    imem_addr  = pc_q[31:2];
    PC_4       = 32'd0;
    inst       = 32'd0;
    inst_valid = 1'b0;
    IF_flush   = 1'b0;
    if_stall   = 1'b0;
    if (rst_n) begin
      PC_4 = pc_plus4;
      case (state_q)
        RUN: begin
          imem_read = 1'b1;
          if (imem_stall) begin
            if_stall = 1'b1;
          end else begin
            inst       = imem_rdata;
            inst_valid = 1'b1;
            IF_flush   = redirect & advance;
          end
        end
        HOLD: begin
          inst       = buf_inst_q;
          inst_valid = 1'b1;
          IF_flush   = redirect & advance;
        end
        DRAIN: begin
          imem_read = 1'b1;
          if_stall  = 1'b1;
        end
        default: begin
          imem_read = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized bench for if_fetch_stage against a behavioural model
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        proc_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_stall;
  logic [31:0] PC_4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        IF_flush;
  logic        if_stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: PC, an optional captured word, an optional stale request with its target.
  logic [31:0] m_pc = 32'd0;
  logic        m_has_word = 1'b0;
  logic [31:0] m_word = 32'd0;
  logic        m_stale = 1'b0;
  logic [31:0] m_target = 32'd0;

  logic [31:0] obs_addr, obs_pc4, obs_inst;
  logic        obs_read, obs_valid, obs_flush, obs_stall;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_write   (pc_write),
    .proc_stall (proc_stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_read  (imem_read),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_stall (imem_stall),
    .PC_4       (PC_4),
    .inst       (inst),
    .inst_valid (inst_valid),
    .IF_flush   (IF_flush),
    .if_stall   (if_stall)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b10, a} ^ 32'h1234_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic pw, input logic ps, input logic rd,
                      input logic [31:0] rpc, input logic st);
    logic        adv;
    logic [31:0] tgt, word;
    logic        e_read, e_valid, e_flush, e_stall;
    logic [31:0] e_inst;
    logic [31:0] n_pc, n_word, n_target;
    logic        n_has, n_stale;
    rst_n = r; pc_write = pw; proc_stall = ps; redirect = rd; redirect_pc = rpc; imem_stall = st;
    @(negedge clk);
    obs_addr  = {2'b00, imem_addr};
    obs_pc4   = PC_4;
    obs_inst  = inst;
    obs_read  = imem_read;
    obs_valid = inst_valid;
    obs_flush = IF_flush;
    obs_stall = if_stall;

    adv  = pw & ~ps;
    tgt  = {rpc[31:2], 2'b00};
    word = mem_word(m_pc[31:2]);
    n_pc = m_pc; n_has = m_has_word; n_word = m_word; n_stale = m_stale; n_target = m_target;
    e_read = 1'b0; e_valid = 1'b0; e_flush = 1'b0; e_stall = 1'b0; e_inst = 32'd0;

    if (!r) begin
      check("rst_pc4", obs_pc4, 32'd0);
      n_pc = 32'd0; n_has = 1'b0; n_word = 32'd0; n_stale = 1'b0; n_target = 32'd0;
    end else if (m_stale) begin
      e_read = 1'b1; e_stall = 1'b1;
      if (rd) n_target = tgt;
      if (!st) begin
        n_pc = n_target;
        n_stale = 1'b0;
      end
    end else if (m_has_word) begin
      e_valid = 1'b1; e_inst = m_word; e_flush = rd & adv;
      if (adv) begin
        n_pc = rd ? tgt : m_pc + 32'd4;
        n_has = 1'b0;
      end
    end else begin
      e_read = 1'b1;
      if (st) begin
        e_stall = 1'b1;
        if (rd) begin
          n_target = tgt;
          n_stale = 1'b1;
        end
      end else begin
        e_valid = 1'b1; e_inst = word; e_flush = rd & adv;
        if (adv) n_pc = rd ? tgt : m_pc + 32'd4;
        else begin
          n_has = 1'b1;
          n_word = word;
        end
      end
    end

    check("imem_read", {31'd0, obs_read}, {31'd0, e_read});
    if (r && e_read) check("imem_addr", obs_addr, {2'b00, m_pc[31:2]});
    check("inst", obs_inst, e_inst);
    check("inst_valid", {31'd0, obs_valid}, {31'd0, e_valid});
    if (r && e_valid) check("PC_4", obs_pc4, m_pc + 32'd4);
    check("IF_flush", {31'd0, obs_flush}, {31'd0, e_flush});
    check("if_stall", {31'd0, obs_stall}, {31'd0, e_stall});

    @(posedge clk);
    m_pc = n_pc; m_has_word = n_has; m_word = n_word; m_stale = n_stale; m_target = n_target;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; proc_stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; imem_stall = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("reset_read", {31'd0, obs_read}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      check("seq_addr", obs_addr, i);
      check("seq_pc4", obs_pc4, 4 * (i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      check("stall_if_stall", {31'd0, obs_stall}, 32'd1);
      check("stall_addr", obs_addr, 32'h4);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("stall_done_pc4", obs_pc4, 32'h14);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("hold_enter_addr", obs_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("hold_read", {31'd0, obs_read}, 32'd0);
    check("hold_inst", obs_inst, 32'h9234_0008);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("hold_release_inst", obs_inst, 32'h9234_0008);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("hold_next_addr", obs_addr, 32'h9);

    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check("redir_addr", obs_addr, 32'h10);
    check("redir_flush", {31'd0, obs_flush}, 32'd1);

    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check("redir_target_addr", obs_addr, 32'h40);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
    check("drain_flush", {31'd0, obs_flush}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("drain_valid", {31'd0, obs_valid}, 32'd0);
    check("drain_old_addr", obs_addr, 32'h40);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b1);
    check("drain_new_addr", obs_addr, 32'hC0);

    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    check("post_reset_addr", obs_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("wrap_addr", obs_addr, 32'h3FFF_FFFF);
    check("wrap_pc4", obs_pc4, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check("wrap_next_addr", obs_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 15),
           $urandom(),
           ($urandom_range(0, 9) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `IF_ID_reg`. It owns the PC and runs a variable-latency request/stall handshake with instruction memory. It delivers `PC_4`/`inst` to `IF_ID_reg` each cycle and raises `IF_flush` on taken branches/jumps. A one-entry hold buffer and a pending-redirect register keep fetch correct under pipeline stalls and memory stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pc_write`  in  1  from hazard unit; 0 = load-use stall, hold PC.
- `proc_stall`  in  1  global pipeline stall (data memory busy).
- `redirect`  in  1  taken branch/jump resolved in ID.
- `redirect_pc`  in  32  target; bits [1:0] ignored (treated as 0).
- `imem_read`  out  1  instruction memory request.
- `imem_addr`  out  30  word address, = pc[31:2].
- `imem_rdata`  in  32  instruction word; valid when `imem_read`=1 and `imem_stall`=0.
- `imem_stall`  in  1  memory busy; address must be held stable while high.
- `PC_4`  out  32  pc+4 of the delivered instruction, to `IF_ID_reg`.
- `inst`  out  32  delivered instruction; 32'b0 (NOP) when `inst_valid`=0.
- `inst_valid`  out  1  `inst` is a real fetched word this cycle.
- `IF_flush`  out  1  redirect accepted; `IF_ID_reg` must load zeros.
- `if_stall`  out  1  fetch cannot deliver; OR'd into `proc_stall` by top level.

## Operation
- Internal state: `pc`[31:0], `buf_inst`[31:0], `pend_pc`[31:0], FSM {RUN, HOLD, DRAIN}.
- advance = `pc_write` & ~`proc_stall`. Redirect is accepted only when advance=1; otherwise it is ignored, and the hazard unit re-presents it.
- RUN: `imem_read`=1, `imem_addr`=pc[31:2].
  - `imem_stall`=1: `if_stall`=1, `inst_valid`=0, `inst`=0. PC held. If `redirect`=1 (regardless of advance): `pend_pc`<=redirect_pc, go DRAIN.
  - `imem_stall`=0 and advance: `inst`=`imem_rdata`, `inst_valid`=1, `PC_4`=pc+4. pc <= `redirect` ? redirect_pc : pc+4. `IF_flush`=`redirect`. Stay RUN.
  - `imem_stall`=0 and not advance: `buf_inst`<=`imem_rdata`, go HOLD.
- HOLD: `imem_read`=0, `inst`=`buf_inst`, `inst_valid`=1, `PC_4`=pc+4, `if_stall`=0. On advance: pc <= `redirect` ? redirect_pc : pc+4, `IF_flush`=`redirect`, go RUN.
- DRAIN: `imem_read`=1 with the old address (the in-flight request completes). `if_stall`=1, `inst_valid`=0. A further `redirect` overwrites `pend_pc`. On `imem_stall`=0: the word is discarded, pc<=`pend_pc`, go RUN.
- PC arithmetic is 32-bit modulo: pc 32'hFFFF_FFFC + 4 wraps to 0.
- `IF_flush` and advance coincide only in RUN/HOLD; `IF_flush` is never asserted in DRAIN.

## Timing
- Reset (`rst_n`=0 sampled at posedge): pc<=RESET_PC, FSM<=RUN, buf_inst<=0, pend_pc<=0. While `rst_n`=0, all outputs are forced combinationally: `imem_read`=0, `inst`=0, `inst_valid`=0, `if_stall`=0, `IF_flush`=0, `PC_4`=0.
- Reset asserted mid-DRAIN or HOLD abandons the pending word/redirect. The first request after reset is issued the cycle `rst_n` is seen high.
- Zero-wait memory: one instruction per cycle. pc changes on the posedge following completion.
- N-cycle `imem_stall`: `if_stall` high exactly N cycles; the instruction is delivered in cycle N+1.
- Redirect latency: target address appears on `imem_addr` in the cycle after acceptance (RUN/HOLD), or in the cycle after drain completion (DRAIN).
- All outputs are combinational from state + inputs. No output depends combinationally on `imem_rdata` except `inst`.

## Test plan
- Reset with RESET_PC=0, zero-wait memory returning addr-tagged words, advance=1 -> `imem_addr` sequence 0,1,2,3. `PC_4` 4,8,12,16. `inst_valid`=1 every cycle.
- `imem_stall` high 3 cycles at pc=0x10 -> `if_stall`=1 for 3 cycles, `imem_addr`=0x4 stable. Word delivered with `PC_4`=0x14 in cycle 4.
- Completion with `pc_write`=0 for 2 cycles at pc=0x20 -> `imem_read`=0 in HOLD, `inst` held = word@0x20. Delivered once after release; next `imem_addr`=0x9.
- `redirect`=1, `redirect_pc`=0x103 on a completing fetch at pc=0x40 -> `IF_flush`=1 that cycle, next `imem_addr`=0x40 (pc=0x100).
- `redirect` to 0x200 during `imem_stall`, then a second redirect to 0x300 while still draining -> stale word discarded, no `inst_valid`, no `IF_flush`, next `imem_addr`=0xC0.
- `rst_n`=0 during DRAIN, and pc=0xFFFFFFFC wrap -> after reset `imem_addr`=RESET_PC>>2. Wrap case: next pc=0.
